// File: rtl/merge_tree_pkg.sv
// Shared types and default sizing for the merger-tree front end.
// Holds the leaf refill FSM state encoding and the default request layout.
package merge_tree_pkg;

    localparam int NUM_LEAVES = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int BURST      = 4;
    localparam int MAX_OUTST  = 8;
    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 24;
    localparam int TAG_W      = $clog2(NUM_LEAVES);
    localparam int CRED_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [$clog2(BURST):0] len;
        logic [TAG_W-1:0]       tag;
    } refill_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Leaf FIFO refill scheduler: streams every leaf's sorted run from memory in credit-gated
// bursts, sharing one read-request port round-robin, and pulses o_done when the pass drains.
module leaf_refill_scheduler
    import merge_tree_pkg::sched_state_e, merge_tree_pkg::ST_IDLE, merge_tree_pkg::ST_RUN,
           merge_tree_pkg::ST_DRAIN, merge_tree_pkg::ST_DONE;
#(
    parameter int NUM_LEAVES = merge_tree_pkg::NUM_LEAVES,
    parameter int FIFO_DEPTH = merge_tree_pkg::FIFO_DEPTH,
    parameter int BURST      = merge_tree_pkg::BURST,
    parameter int MAX_OUTST  = merge_tree_pkg::MAX_OUTST,
    parameter int ADDR_W     = merge_tree_pkg::ADDR_W,
    parameter int LEN_W      = merge_tree_pkg::LEN_W,
    localparam int TAG_W     = $clog2(NUM_LEAVES),
    localparam int BLEN_W    = $clog2(BURST) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [LEN_W-1:0]      i_run_len,
    input  logic [NUM_LEAVES-1:0] i_fifo_read,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [ADDR_W-1:0]     o_req_addr,
    output logic [BLEN_W-1:0]     o_req_len,
    output logic [TAG_W-1:0]      o_req_tag,
    input  logic                  i_resp_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BLEN_W-1:0] len;
        logic [TAG_W-1:0]  tag;
    } req_t;

    sched_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     base_q;
    logic [LEN_W-1:0]      run_len_q;
    logic [CRED_W-1:0]     credits_q [NUM_LEAVES];
    logic [CRED_W-1:0]     credits_d [NUM_LEAVES];
    logic [LEN_W-1:0]      remaining_q [NUM_LEAVES];
    logic [LEN_W-1:0]      remaining_d [NUM_LEAVES];
    logic [LEN_W-1:0]      offset_q [NUM_LEAVES];
    logic [LEN_W-1:0]      offset_d [NUM_LEAVES];
    logic [BLEN_W-1:0]     burst_len [NUM_LEAVES];
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [TAG_W-1:0]      rr_ptr_q;
    logic                  req_valid_q;
    req_t                  req_q, next_req;
    logic [NUM_LEAVES-1:0] eligible, grant;
    logic [TAG_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [BLEN_W-1:0]     sel_len;
    logic [LEN_W-1:0]      sel_offset;
    logic                  accept, all_empty, resp_dec, start_pass, cred_overflow;

    assign accept     = req_valid_q && i_req_ready;
    assign start_pass = (state_q == ST_IDLE) && i_start;
    assign resp_dec   = i_resp_last && (outst_q != '0);

    // Grants are only considered while no request is pending, so the pending one is never double-counted.
    always_comb begin
        burst_len = '{default: '0};
        eligible  = '0;
        all_empty = 1'b1;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            burst_len[k] = (remaining_q[k] >= LEN_W'(BURST)) ? BLEN_W'(BURST)
                                                              : remaining_q[k][BLEN_W-1:0];
            eligible[k]  = (state_q == ST_RUN) && !req_valid_q && (remaining_q[k] != '0)
                        && (int'(credits_q[k]) >= int'(burst_len[k]))
                        && (int'(outst_q) < MAX_OUTST);
            if (remaining_q[k] != '0) all_empty = 1'b0;
        end
    end

    rr_arbiter #(.N(NUM_LEAVES)) u_arb (
        .req         (eligible),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_len    = '0;
        sel_offset = '0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            if (grant[k]) begin
                sel_len    = sel_len | burst_len[k];
                sel_offset = sel_offset | offset_q[k];
            end
        end
        next_req.addr = base_q + ADDR_W'(grant_idx) * ADDR_W'(run_len_q) + ADDR_W'(sel_offset);
        next_req.len  = sel_len;
        next_req.tag  = grant_idx;
    end

    // Same-cycle dequeue and accept on one leaf net out; anything above FIFO_DEPTH is a tree bug.
    always_comb begin
        int sum;
        sum           = 0;
        cred_overflow = 1'b0;
        credits_d     = credits_q;
        remaining_d   = remaining_q;
        offset_d      = offset_q;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            if (start_pass) begin
                credits_d[k]   = CRED_W'(FIFO_DEPTH);
                remaining_d[k] = i_run_len;
                offset_d[k]    = '0;
            end else begin
                sum = int'(credits_q[k]) + int'(i_fifo_read[k]);
                if (accept && (req_q.tag == TAG_W'(k))) begin
                    sum            = sum - int'(req_q.len);
                    remaining_d[k] = remaining_q[k] - LEN_W'(req_q.len);
                    offset_d[k]    = offset_q[k] + LEN_W'(req_q.len);
                end
                if (sum > FIFO_DEPTH) begin
                    cred_overflow = 1'b1;
                    credits_d[k]  = CRED_W'(FIFO_DEPTH);
                end else begin
                    credits_d[k]  = CRED_W'(sum);
                end
            end
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (start_pass)              outst_d = '0;
        else if (accept && !resp_dec) outst_d = outst_q + OUT_W'(1);
        else if (!accept && resp_dec) outst_d = outst_q - OUT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_start)         state_d = ST_RUN;
            ST_RUN:   if (all_empty)       state_d = ST_DRAIN;
            ST_DRAIN: if (outst_q == '0)   state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            run_len_q   <= '0;
            outst_q     <= '0;
            rr_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
            for (int k = 0; k < NUM_LEAVES; k++) begin
                credits_q[k]   <= CRED_W'(FIFO_DEPTH);
                remaining_q[k] <= '0;
                offset_q[k]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            outst_q     <= outst_d;
            credits_q   <= credits_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            if (start_pass) begin
                base_q    <= i_base_addr;
                run_len_q <= i_run_len;
            end
            if (accept) begin
                req_valid_q <= 1'b0;
                rr_ptr_q    <= (req_q.tag == TAG_W'(NUM_LEAVES - 1)) ? '0 : req_q.tag + TAG_W'(1);
            end else if (grant_valid) begin
                req_valid_q <= 1'b1;
                req_q       <= next_req;
            end
        end
    end

    assign o_req_valid = req_valid_q;
    assign o_req_addr  = req_q.addr;
    assign o_req_len   = req_q.len;
    assign o_req_tag   = req_q.tag;
    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);

    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!cred_overflow);
            assert (!(i_resp_last && (outst_q == '0)));
        end
    end

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Randomized bench for leaf_refill_scheduler against a per-leaf item/credit model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_leaf_refill_scheduler;

    localparam int NL = 4, DEPTH = 8, BURST = 4, MAXO = 3, AW = 32, LW = 24;

    logic          clk = 1'b0, rst_n = 1'b0, start_in = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] run_len = '0;
    logic [NL-1:0] fifo_read = '0;
    logic          req_ready = 1'b0, resp_last = 1'b0;
    logic          req_valid, busy, done;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_len;
    logic [1:0]    req_tag;

    leaf_refill_scheduler #(.NUM_LEAVES(NL), .FIFO_DEPTH(DEPTH), .BURST(BURST),
                            .MAX_OUTST(MAXO), .ADDR_W(AW), .LEN_W(LW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_in), .i_base_addr(base_addr),
        .i_run_len(run_len), .i_fifo_read(fifo_read), .o_req_valid(req_valid),
        .i_req_ready(req_ready), .o_req_addr(req_addr), .o_req_len(req_len),
        .o_req_tag(req_tag), .i_resp_last(resp_last), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cred_m[NL], rem_m[NL], off_m[NL], items[NL];
    int outst_m = 0, ptr_m = 0, done_cnt = 0, len_m = 0;
    logic [AW-1:0] base_m = '0;
    int acc_tag[$], acc_len[$];
    logic [AW-1:0] acc_addr[$];
    logic          hold_pending = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [2:0]    hold_len;
    logic [1:0]    hold_tag;
    int ready_pct = 100, read_pct = 0, resp_pct = 100;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: check the outputs seen now, drive inputs, advance the model as the next edge will.
    task automatic applyStimulus(input logic start, input logic ready, input logic [NL-1:0] rd, input logic resp);
        int t, exp_len;
        logic [AW-1:0] exp_addr;
        if (hold_pending) begin
            checkOutput("hold_valid", req_valid, 1);
            checkOutput("hold_addr", req_addr, hold_addr);
            checkOutput("hold_len", req_len, hold_len);
            checkOutput("hold_tag", req_tag, hold_tag);
        end
        start_in = start; req_ready = ready; fifo_read = rd; resp_last = resp;
        base_addr = base_m; run_len = LW'(len_m);
        if (done) begin
            done_cnt++;
            checkOutput("busy_in_done", busy, 0);
        end
        if (start) begin
            for (int k = 0; k < NL; k++) begin
                cred_m[k] = DEPTH; rem_m[k] = len_m; off_m[k] = 0; items[k] = 0;
            end
            outst_m = 0;
        end else begin
            if (req_valid && ready) begin
                t = int'(req_tag);
                exp_len = (rem_m[t] < BURST) ? rem_m[t] : BURST;
                exp_addr = base_m + AW'(t * len_m) + AW'(off_m[t]);
                checkOutput("req_busy", busy, 1);
                checkOutput("req_len", req_len, exp_len);
                checkOutput("req_addr", req_addr, exp_addr);
                checkOutput("req_credit_ok", cred_m[t] >= exp_len, 1);
                checkOutput("req_outst_ok", outst_m < MAXO, 1);
                acc_tag.push_back(t); acc_len.push_back(int'(req_len)); acc_addr.push_back(req_addr);
                cred_m[t] -= exp_len; rem_m[t] -= exp_len; off_m[t] += exp_len;
                items[t] += int'(req_len);
                outst_m++;
                ptr_m = (t + 1) % NL;
            end
            for (int k = 0; k < NL; k++) if (rd[k]) cred_m[k]++;
            if (resp) outst_m--;
        end
        hold_pending = req_valid && !ready;
        hold_addr = req_addr; hold_len = req_len; hold_tag = req_tag;
        @(negedge clk);
    endtask

    task automatic randomCycle();
        logic ready, resp;
        logic [NL-1:0] rd;
        ready = ($urandom_range(99) < ready_pct);
        for (int k = 0; k < NL; k++) rd[k] = (cred_m[k] < DEPTH) && ($urandom_range(99) < read_pct);
        resp = (outst_m > 0) && ($urandom_range(99) < resp_pct);
        applyStimulus(1'b0, ready, rd, resp);
    endtask

    task automatic startPass(input logic [AW-1:0] base, input int len);
        acc_tag.delete(); acc_len.delete(); acc_addr.delete();
        done_cnt = 0; base_m = base; len_m = len;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic finishPass(input int max_cycles);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cycles) begin randomCycle(); n++; end
        checkOutput("pass_done", done_cnt > 0, 1);
        repeat (3) randomCycle();
        checkOutput("done_once", done_cnt, 1);
        checkOutput("idle_busy", busy, 0);
        for (int k = 0; k < NL; k++) checkOutput("leaf_items", items[k], len_m);
    endtask

    task automatic doReset();
        rst_n = 1'b0; start_in = 1'b0; req_ready = 1'b0; fifo_read = '0; resp_last = 1'b0;
        hold_pending = 1'b0; outst_m = 0; ptr_m = 0; done_cnt = 0;
        for (int k = 0; k < NL; k++) begin cred_m[k] = DEPTH; rem_m[k] = 0; off_m[k] = 0; end
        @(negedge clk); @(negedge clk);
        checkOutput("rst_valid", req_valid, 0);
        checkOutput("rst_addr", req_addr, 0);
        checkOutput("rst_len", req_len, 0);
        checkOutput("rst_tag", req_tag, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int p0, n, t;
        logic [AW-1:0] snap_addr;
        @(negedge clk);
        doReset();

        // Full bursts, everything eligible: strict round-robin over two rounds.
        p0 = ptr_m; ready_pct = 100; read_pct = 0; resp_pct = 100;
        startPass(0, 8);
        finishPass(500);
        checkOutput("t1_count", acc_tag.size(), 8);
        for (int i = 0; i < 8 && i < acc_tag.size(); i++) begin
            t = (p0 + i) % NL;
            checkOutput("t1_tag", acc_tag[i], t);
            checkOutput("t1_addr", acc_addr[i], t * 8 + (i / NL) * 4);
            checkOutput("t1_len", acc_len[i], 4);
        end

        // Credits exhausted: stall until leaf 2 gets four dequeues back.
        p0 = ptr_m;
        startPass(0, 12);
        repeat (40) randomCycle();
        checkOutput("t2_count", acc_tag.size(), 8);
        checkOutput("t2_stall", req_valid, 0);
        for (int i = 0; i < 8 && i < acc_tag.size(); i++) begin
            t = (p0 + i) % NL;
            checkOutput("t2_tag", acc_tag[i], t);
            checkOutput("t2_addr", acc_addr[i], t * 12 + (i / NL) * 4);
        end
        repeat (4) applyStimulus(1'b0, 1'b1, 4'b0100, outst_m > 0);
        n = 0;
        while (acc_tag.size() < 9 && n < 20) begin randomCycle(); n++; end
        checkOutput("t2_refill_count", acc_tag.size(), 9);
        if (acc_tag.size() >= 9) begin
            checkOutput("t2_refill_tag", acc_tag[8], 2);
            checkOutput("t2_refill_addr", acc_addr[8], 32);
            checkOutput("t2_refill_len", acc_len[8], 4);
        end
        read_pct = 60;
        finishPass(2000);
        read_pct = 0;

        // Short final bursts.
        p0 = ptr_m;
        startPass(1000, 6);
        finishPass(500);
        checkOutput("t3_count", acc_tag.size(), 8);
        for (int i = 0; i < 8 && i < acc_tag.size(); i++) begin
            t = (p0 + i) % NL;
            checkOutput("t3_tag", acc_tag[i], t);
            checkOutput("t3_len", acc_len[i], (i < NL) ? 4 : 2);
            checkOutput("t3_addr", acc_addr[i], 1000 + t * 6 + ((i < NL) ? 0 : 4));
        end

        // Back-pressure: request held for five cycles, then accepted.
        p0 = ptr_m;
        startPass(0, 4);
        n = 0;
        while (!req_valid && n < 20) begin applyStimulus(1'b0, 1'b0, '0, 1'b0); n++; end
        checkOutput("t4_valid", req_valid, 1);
        snap_addr = req_addr;
        repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t4_held_addr", req_addr, snap_addr);
        checkOutput("t4_none_yet", acc_tag.size(), 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        checkOutput("t4_count", acc_tag.size(), 1);
        if (acc_tag.size() >= 1) begin
            checkOutput("t4_tag", acc_tag[0], p0);
            checkOutput("t4_addr", acc_addr[0], p0 * 4);
        end
        finishPass(500);

        // Outstanding limit with responses withheld.
        resp_pct = 0;
        startPass(0, 8);
        repeat (20) randomCycle();
        checkOutput("t5_count", acc_tag.size(), MAXO);
        checkOutput("t5_blocked", req_valid, 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b1);
        repeat (8) randomCycle();
        checkOutput("t5_count_after_resp", acc_tag.size(), MAXO + 1);
        checkOutput("t5_blocked_again", req_valid, 0);
        resp_pct = 100; read_pct = 50;
        finishPass(2000);

        // Reset in the middle of a pass, then a clean pass from offset 0.
        resp_pct = 0; read_pct = 0;
        startPass(0, 8);
        repeat (20) randomCycle();
        checkOutput("t6_outst_before_reset", acc_tag.size(), MAXO);
        doReset();
        resp_pct = 100; read_pct = 50;
        startPass(200, 8);
        finishPass(2000);
        if (acc_tag.size() >= 1) begin
            checkOutput("t6_first_tag", acc_tag[0], 0);
            checkOutput("t6_first_addr", acc_addr[0], 200);
        end

        // Zero-length runs complete without requests.
        startPass(0, 0);
        finishPass(50);
        checkOutput("t7_no_reqs", acc_tag.size(), 0);

        repeat (6) begin
            ready_pct = $urandom_range(30, 100);
            read_pct  = $urandom_range(20, 100);
            resp_pct  = $urandom_range(20, 100);
            startPass($urandom, $urandom_range(0, 20));
            finishPass(4000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
